// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready byte stream feeding the UART transmitter FIFO
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    modport master (output data, valid, input ready);
    modport slave  (input data, valid, output ready);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1/8N2 UART transmitter, LSB first, line idle high
module uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [15:0]                 i_clks_per_bit,
    uart_tx_if.slave                    i_bus,
    output logic                        o_tx,
    output logic                        o_busy,
    output logic                        o_tx_done,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t                r_state, w_state_next;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
    logic [15:0]           r_period, w_period_next, r_clk_cnt, w_clk_cnt_next, w_period_in;
    logic [BW-1:0]         r_bit_cnt, w_bit_cnt_next;
    logic                  r_tx, r_tx_done, w_tx_next, w_done_next;
    logic                  w_push, w_pop, w_nempty, w_last_clk;

    assign i_bus.ready  = r_count < DEPTH;
    assign w_push       = i_bus.valid && i_bus.ready;
    assign w_nempty     = r_count != '0;
    assign w_period_in  = i_clks_per_bit < 16'd2 ? 16'd2 : i_clks_per_bit;
    assign w_last_clk   = r_clk_cnt == r_period - 16'd1;
    assign w_tx_next    = w_state_next == S_START ? 1'b0 :
                          w_state_next == S_DATA  ? w_shift_next[0] : 1'b1;
    assign o_tx         = r_tx;
    assign o_tx_done    = r_tx_done;
    assign o_busy       = r_state != S_IDLE;
    assign o_fifo_count = r_count;

    // FIFO storage; never read before written, so no reset needed
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_bus.data;
    end

    // FIFO pointers and occupancy; simultaneous push and pop cancel out
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // frame state, counters and registered line/done outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_period  <= '0;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
            r_tx_done <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_period  <= w_period_next;
            r_clk_cnt <= w_clk_cnt_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_tx      <= w_tx_next;
            r_tx_done <= w_done_next;
        end
    end

    // next frame state; a pop both loads the shifter and latches the bit period
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_period_next  = r_period;
        w_clk_cnt_next = r_clk_cnt + 16'd1;
        w_bit_cnt_next = r_bit_cnt;
        w_pop          = 1'b0;
        w_done_next    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_clk_cnt_next = '0;
                if (w_nempty) begin
                    w_pop          = 1'b1;
                    w_shift_next   = r_mem[r_rd_ptr];
                    w_period_next  = w_period_in;
                    w_bit_cnt_next = '0;
                    w_state_next   = S_START;
                end
            end
            S_START: begin
                if (w_last_clk) begin
                    w_clk_cnt_next = '0;
                    w_bit_cnt_next = '0;
                    w_state_next   = S_DATA;
                end
            end
            S_DATA: begin
                if (w_last_clk) begin
                    w_clk_cnt_next = '0;
                    w_shift_next   = r_shift >> 1;
                    w_bit_cnt_next = r_bit_cnt == LAST_BIT ? '0 : r_bit_cnt + BW'(1);
                    w_state_next   = r_bit_cnt == LAST_BIT ? S_STOP : S_DATA;
                end
            end
            S_STOP: begin
                if (w_last_clk) begin
                    w_clk_cnt_next = '0;
                    w_bit_cnt_next = r_bit_cnt + BW'(1);
                    if (r_bit_cnt == LAST_STOP) begin
                        w_done_next    = 1'b1;
                        w_bit_cnt_next = '0;
                        w_state_next   = S_IDLE;
                        if (w_nempty) begin
                            w_pop         = 1'b1;
                            w_shift_next  = r_mem[r_rd_ptr];
                            w_period_next = w_period_in;
                            w_state_next  = S_START;
                        end
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for the UART transmitter
module tb_uart_tx;
    localparam int TR = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] clks = 16'd4;
    logic        tx, busy, done;
    logic [2:0]  cnt;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic        tr_tx [TR];
    logic        tr_busy [TR];
    logic        tr_done [TR];
    logic [7:0]  vals [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    uart_tx_if #(.DATA_WIDTH(8)) bus ();

    uart_tx #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .i_clks_per_bit(clks), .i_bus(bus),
        .o_tx(tx), .o_busy(busy), .o_tx_done(done), .o_fifo_count(cnt)
    );

    always #5 clk = ~clk;

    // cycle index: value k holds from the posedge opening cycle k
    always @(posedge clk) cyc <= cyc + 1;

    // record line state mid-cycle for post-hoc frame checks
    always @(negedge clk) begin
        if (cyc < TR) begin
            tr_tx[cyc]   <= tx;
            tr_busy[cyc] <= busy;
            tr_done[cyc] <= done;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // offer a byte and hold valid until accepted; c is the accepting cycle
    task automatic push(input logic [7:0] b, output int c);
        int w;
        w = 0;
        bus.data  = b;
        bus.valid = 1'b1;
        while (!bus.ready && w < 2000) begin
            tick(1);
            w++;
        end
        chk("push_wait", 32'(w < 2000), 32'd1);
        c = cyc;
        tick(1);
    endtask

    task automatic check_frame(input logic [7:0] b, input int p, input int s);
        logic [9:0] f;
        logic [7:0] d;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < p; j++)
                chk($sformatf("frame_%02h_bit%0d_cyc%0d", b, i, s + i*p + j), 32'(tr_tx[s + i*p + j]), 32'(f[i]));
        for (int i = 0; i < 8; i++) d[i] = tr_tx[s + (i+1)*p + p/2];
        chk($sformatf("payload_%02h", b), 32'(d), 32'(b));
    endtask

    function automatic int pulses(input int a, input int b);
        int n;
        n = 0;
        for (int i = a; i <= b; i++) if (tr_done[i] === 1'b1) n++;
        return n;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish within 200000 ns");
        $fatal(1);
    end

    initial begin
        int c, c1, c6, d;
        bus.data  = '0;
        bus.valid = 1'b0;
        tick(2);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk("idle_tx", 32'(tx), 32'd1);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_ready", 32'(bus.ready), 32'd1);
            chk("idle_count", 32'(cnt), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
            tick(1);
        end

        clks = 16'd4;
        push(8'hA5, c);
        bus.valid = 1'b0;
        tick(60);
        chk("a5_tx_pre", 32'(tr_tx[c+1]), 32'd1);
        chk("a5_busy_pre", 32'(tr_busy[c+1]), 32'd0);
        chk("a5_busy_first", 32'(tr_busy[c+2]), 32'd1);
        check_frame(8'hA5, 4, c + 2);
        chk("a5_busy_last", 32'(tr_busy[c+41]), 32'd1);
        chk("a5_busy_after", 32'(tr_busy[c+42]), 32'd0);
        chk("a5_done_early", 32'(tr_done[c+41]), 32'd0);
        chk("a5_done", 32'(tr_done[c+42]), 32'd1);
        chk("a5_done_late", 32'(tr_done[c+43]), 32'd0);

        push(8'h00, c);
        push(8'hFF, d);
        push(8'h3C, d);
        bus.valid = 1'b0;
        tick(140);
        check_frame(8'h00, 4, c + 2);
        check_frame(8'hFF, 4, c + 42);
        check_frame(8'h3C, 4, c + 82);
        chk("b2b_done1", 32'(tr_done[c+42]), 32'd1);
        chk("b2b_done2", 32'(tr_done[c+82]), 32'd1);
        chk("b2b_done3", 32'(tr_done[c+122]), 32'd1);
        chk("b2b_busy_gap", 32'(tr_busy[c+42]), 32'd1);
        chk("b2b_busy_end", 32'(tr_busy[c+122]), 32'd0);
        chk("b2b_pulses", 32'(pulses(c, c + 130)), 32'd3);

        clks = 16'd8;
        push(vals[0], c1);
        for (int i = 1; i < 5; i++) push(vals[i], d);
        chk("full_count", 32'(cnt), 32'd4);
        chk("full_ready", 32'(bus.ready), 32'd0);
        push(vals[5], c6);
        bus.valid = 1'b0;
        chk("sixth_accept_cyc", 32'(c6 - c1), 32'd82);
        tick(420);
        for (int i = 0; i < 6; i++) check_frame(vals[i], 8, c1 + 2 + 80*i);
        chk("fill_pulses", 32'(pulses(c1, c1 + 495)), 32'd6);
        chk("fill_tx_end", 32'(tr_tx[c1 + 490]), 32'd1);
        chk("fill_busy_end", 32'(busy), 32'd0);

        clks = 16'd4;
        push(8'h5A, c);
        push(8'hC3, d);
        bus.valid = 1'b0;
        tick(8);
        clks = 16'd6;
        tick(100);
        check_frame(8'h5A, 4, c + 2);
        check_frame(8'hC3, 6, c + 42);
        chk("p6_done", 32'(tr_done[c+102]), 32'd1);
        clks = 16'd0;
        push(8'h96, c);
        bus.valid = 1'b0;
        tick(30);
        check_frame(8'h96, 2, c + 2);
        chk("p2_done", 32'(tr_done[c+22]), 32'd1);

        clks = 16'd4;
        push(8'hF0, c);
        push(8'h0F, d);
        push(8'h81, d);
        bus.valid = 1'b0;
        tick(9);
        chk("mid_tx", 32'(tx), 32'd0);
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_count", 32'(cnt), 32'd2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(cnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        for (int i = 0; i < 100; i++) begin
            chk($sformatf("post_rst_quiet_%0d", i), {28'd0, tx, busy, done, 1'b0}, {28'd0, 4'b1000});
            tick(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
